// File: rtl/inst_prefetch_pkg.sv
// Shared types for the instruction prefetch buffer.
// Optional feature macro: INST_PREFETCH_ERR_EN (bus-error tagging and fetch stop).
package inst_prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } entry_t;

  localparam int unsigned WORD_BYTES = 4;

  // Clears the byte-offset bits so every bus address is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO of prefetched {pc, inst, err} entries.
// clear_i has priority over push_i and pop_i; a push while full is accepted
// only together with a pop, so the count stays unchanged in that case.
module prefetch_fifo
  import inst_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          push_i,
  input  entry_t        entry_i,
  input  logic          pop_i,
  output entry_t        head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            push_ok;
  logic            pop_ok;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  // Storage, pointers and occupancy; clear only resets the bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= entry_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetch buffer: sequential word fetches over a req/ack bus,
// queued {pc, inst, err} entries handed to fetch with valid/ready, flushed
// and restarted on redirect. At most one bus request is outstanding.
// Optional feature macro: INST_PREFETCH_ERR_EN -- entries carry mem_err and
// fetching stops after an error entry until the next redirect.
module inst_prefetch
  import inst_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  localparam int unsigned CW       = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C  = (CW + 1)'(DEPTH);
  localparam logic [31:0] WORD_INC = 32'(WORD_BYTES);

  state_e        state_q;
  logic [31:0]   fetch_pc_q;
  logic          mem_req_q;
  logic [31:0]   mem_addr_q;
  logic          blocked_q;

  logic          push;
  logic          pop;
  logic          ack_err;
  entry_t        push_entry;
  entry_t        head;
  logic          fifo_empty;
  logic          fifo_full_unused;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   count_after;
  logic          room;
  logic [31:0]   redirect_pc_al;
  logic [31:0]   pc_next;

`ifdef INST_PREFETCH_ERR_EN
  assign ack_err = mem_err;
`else
  logic unused_mem_err;
  assign unused_mem_err = mem_err;
  assign ack_err        = 1'b0;
`endif

  assign redirect_pc_al = word_align(redirect_pc);
  assign pc_next        = fetch_pc_q + WORD_INC;

  // A response is kept only for a live request; redirect discards it.
  assign push = (state_q == REQ) & mem_ack & ~redirect;
  assign pop  = ~fifo_empty & out_ready & ~redirect;

  assign push_entry.pc   = mem_addr_q;
  assign push_entry.inst = mem_rdata;
  assign push_entry.err  = ack_err;

  // Room is judged on the occupancy after this cycle's push/pop.
  assign count_after = {1'b0, fifo_count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
  assign room        = (count_after < DEPTH_C);

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (redirect),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full_unused),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign out_valid = ~fifo_empty;
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;
  assign out_err   = head.err;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;

  // Fetch FSM with registered bus request/address.
  // A redirect seen in IDLE launches the new-PC request directly so the
  // bus request appears one cycle after the redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      blocked_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect) begin
            fetch_pc_q <= redirect_pc_al;
            mem_addr_q <= redirect_pc_al;
            mem_req_q  <= 1'b1;
            blocked_q  <= 1'b0;
            state_q    <= REQ;
          end else if (room && !blocked_q) begin
            mem_addr_q <= fetch_pc_q;
            mem_req_q  <= 1'b1;
            state_q    <= REQ;
          end
        end
        REQ: begin
          if (redirect) begin
            fetch_pc_q <= redirect_pc_al;
            blocked_q  <= 1'b0;
            if (mem_ack) begin
              mem_req_q <= 1'b0;
              state_q   <= IDLE;
            end else begin
              state_q   <= DROP;
            end
          end else if (mem_ack) begin
            fetch_pc_q <= pc_next;
            if (ack_err) begin
              blocked_q <= 1'b1;
              mem_req_q <= 1'b0;
              state_q   <= IDLE;
            end else if (room) begin
              mem_addr_q <= pc_next;
            end else begin
              mem_req_q <= 1'b0;
              state_q   <= IDLE;
            end
          end
        end
        DROP: begin
          if (redirect) begin
            fetch_pc_q <= redirect_pc_al;
            blocked_q  <= 1'b0;
          end
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_prefetch.sv
// Bench for inst_prefetch: a bus responder model generates memory data and
// pushes each expected delivery into a scoreboard queue; a monitor pops and
// compares on every fetch handshake. Build with INST_PREFETCH_ERR_EN to
// exercise the bus-error stop.
module tb_inst_prefetch;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;

  always #5 clk = ~clk;

  inst_prefetch #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .out_err     (out_err),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .mem_err     (mem_err)
  );

  int          n_pass = 0;
  int          n_total = 0;
  exp_t        sb[$];
  logic [31:0] req_log[$];
  logic [31:0] salt;

  int unsigned lat_lo = 0;
  int unsigned lat_hi = 0;
  bit          rand_err_en = 0;
  bit          err_addr_en = 0;
  logic [31:0] err_addr = 32'h0;

  // responder state
  bit          r_busy = 0;
  int unsigned r_wait = 0;
  logic [31:0] r_cur = 32'h0;
  bit          r_stale = 0;
  bit          r_blocked = 0;
  logic [31:0] r_exp_pc = RESET_PC;
  bit          r_pend = 0;
  exp_t        r_pe;
  exp_t        m_e;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ salt;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h at %0t", nm, act, exp, $time);
  endtask

  task automatic fail_timeout(input string nm);
    n_total++;
    $display("FAIL %s: timed out waiting at %0t", nm, $time);
  endtask

  // Called shortly after a rising edge; leaves redirect low one cycle later.
  task automatic pulse_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    @(negedge clk);
    req_log.delete();
    @(posedge clk);
    #1;
    redirect = 1'b0;
  endtask

  // Bus responder and reference model of the delivered stream.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    mem_err   = 1'b0;
    forever begin
      @(posedge clk);
      if (r_pend) begin
        sb.push_back(r_pe);
        r_pend = 0;
      end
      #1;
      mem_ack = 1'b0;
      mem_err = 1'b0;
      if (rst_n && mem_req) begin
        if (!r_busy) begin
          r_busy = 1;
          r_cur  = mem_addr;
          r_wait = $urandom_range(lat_hi, lat_lo);
          req_log.push_back(mem_addr);
`ifdef INST_PREFETCH_ERR_EN
          chk("no_req_while_blocked", 32'(r_blocked), 32'h0);
`endif
        end else begin
          chk("req_addr_held", mem_addr, r_cur);
        end
        if (r_wait == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = memf(mem_addr);
          mem_err   = err_addr_en ? (mem_addr == err_addr)
                                  : (rand_err_en && ($urandom_range(15, 0) == 0));
          r_busy    = 0;
        end else begin
          r_wait--;
        end
      end
      @(negedge clk);
      if (rst_n) begin
        if (mem_req && mem_ack) begin
          if (redirect || r_stale) begin
            r_stale = 0;
          end else begin
            chk("req_addr_order", mem_addr, r_exp_pc);
            r_exp_pc  = r_exp_pc + 32'd4;
            r_pe.pc   = mem_addr;
            r_pe.inst = mem_rdata;
`ifdef INST_PREFETCH_ERR_EN
            r_pe.err  = mem_err;
            if (mem_err) r_blocked = 1;
`else
            r_pe.err  = 1'b0;
`endif
            r_pend = 1;
          end
        end else if (mem_req && redirect) begin
          r_stale = 1;
        end
        if (redirect) begin
          r_exp_pc  = redirect_pc & ~32'h3;
          r_blocked = 0;
        end
      end
    end
  end

  // Monitor: compare each handshake against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        if (redirect) begin
          sb.delete();
        end else if (out_valid && out_ready && sb.size() != 0) begin
          m_e = sb.pop_front();
          chk("out_pc", out_pc, m_e.pc);
          chk("out_inst", out_inst, m_e.inst);
          chk("out_err", 32'(out_err), 32'(m_e.err));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    bit found;
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    out_ready   = 1'b0;
    salt        = $urandom;

    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_addr", mem_addr, RESET_PC);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_err", 32'(out_err), 32'h0);

    // Streaming from reset, single-cycle acks.
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("seq_len", 32'(req_log.size() >= 4), 32'h1);
    for (int i = 0; i < 4; i++)
      if (i < req_log.size()) chk("seq_addr", req_log[i], 32'(4 * i));

    // Back-pressure: exactly DEPTH requests, then one per pop.
    out_ready = 1'b0;
    pulse_redirect(32'h0);
    repeat (20) @(posedge clk);
    #1;
    chk("full_req_count", 32'(req_log.size()), 32'(DEPTH));
    chk("full_req_idle", 32'(mem_req), 32'h0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pop_req_count", 32'(req_log.size()), 32'(DEPTH + 1));
    if (req_log.size() > DEPTH) chk("pop_req_addr", req_log[DEPTH], 32'd16);
    chk("pop_req_idle", 32'(mem_req), 32'h0);

    // Redirect while the request to 8 is outstanding.
    lat_lo = 3; lat_hi = 3;
    out_ready = 1'b1;
    pulse_redirect(32'h0);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk); #2;
      if (mem_req && mem_addr == 32'h8) found = 1;
    end
    if (!found) fail_timeout("wait_req8");
    pulse_redirect(32'h100);
    #1;
    chk("drop_req_held", 32'(mem_req), 32'h1);
    chk("drop_addr_held", mem_addr, 32'h8);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk); #2;
      if (req_log.size() != 0) found = 1;
    end
    if (!found) fail_timeout("wait_req100");
    else begin
      chk("redir_addr", req_log[0], 32'h100);
      chk("redir_no_valid", 32'(out_valid), 32'h0);
    end

    // Redirect coinciding with an ack.
    lat_lo = 1; lat_hi = 1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk); #2;
      if (mem_ack) found = 1;
    end
    if (!found) fail_timeout("wait_ack");
    pulse_redirect(32'h203);
    @(negedge clk);
    chk("ack_redir_empty", 32'(out_valid), 32'h0);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk); #2;
      if (req_log.size() != 0) found = 1;
    end
    if (!found) fail_timeout("wait_req200");
    else chk("ack_redir_addr", req_log[0], 32'h200);

    // Address wrap.
    lat_lo = 0; lat_hi = 0;
    @(posedge clk); #1;
    pulse_redirect(32'hFFFF_FFF8);
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(posedge clk); #2;
      if (req_log.size() >= 3) found = 1;
    end
    if (!found) fail_timeout("wait_wrap");
    else begin
      chk("wrap_addr0", req_log[0], 32'hFFFF_FFF8);
      chk("wrap_addr1", req_log[1], 32'hFFFF_FFFC);
      chk("wrap_addr2", req_log[2], 32'h0000_0000);
    end

`ifdef INST_PREFETCH_ERR_EN
    // Bus error at address 4 stops prefetch until a redirect.
    err_addr_en = 1; err_addr = 32'h4;
    @(posedge clk); #1;
    pulse_redirect(32'h0);
    repeat (20) @(posedge clk);
    #1;
    chk("err_req_count", 32'(req_log.size()), 32'd2);
    chk("err_req_idle", 32'(mem_req), 32'h0);
    err_addr_en = 0;
    pulse_redirect(32'h0);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk); #2;
      if (req_log.size() != 0) found = 1;
    end
    if (!found) fail_timeout("wait_resume");
    else chk("err_resume_addr", req_log[0], 32'h0);
`endif

    // Randomized traffic.
    lat_lo = 0; lat_hi = 3;
    rand_err_en = 1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(3, 0) != 0);
      if (!redirect && $urandom_range(40, 0) == 0) begin
        redirect    = 1'b1;
        redirect_pc = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F))
                                                  : $urandom;
      end else begin
        redirect = 1'b0;
      end
    end
    @(posedge clk); #1;
    redirect  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
